// File: rtl/cla16_chk_pkg.sv
// Shared definitions for the CLA16 result checker: FSM encoding, default
// sizes and the bit-counter width helper.
package cla16_chk_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_CMP  = 2'd2,
      ST_RESP = 2'd3
   } chk_state_e;

   // Counter must index bits 0..w-1; never narrower than one bit.
   function automatic int unsigned bitcnt_w(input int unsigned w);
      if (w < 2) return 1;
      return $clog2(w);
   endfunction

endpackage

// File: rtl/chk_serial_fa.sv
// One-bit full adder with a registered carry; the carry is loaded at
// transaction accept and advanced once per serial calculation cycle.
module chk_serial_fa (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic load_c,
   input  logic en,
   input  logic a,
   input  logic b,
   output logic s,
   output logic cout,
   output logic c
);

   always_comb begin
      s    = a ^ b ^ c;
      cout = (a & b) | (c & (a ^ b));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         c <= 1'b0;
      else if (load)
         c <= load_c;
      else if (en)
         c <= cout;
   end

endmodule

// File: rtl/cla16_result_checker.sv
// Response checker for the 16-bit CLA add/sub unit: bit-serial golden sum,
// compare and saturating pass/fail counters. Optional CHK_ERR_CAPTURE_EN
// adds sticky capture of the first failing transaction.
module cla16_result_checker
   import cla16_chk_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_sign,
   input  logic [WIDTH-1:0] in_res,
   input  logic             in_ovf,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_pass,
   output logic [WIDTH-1:0] rsp_exp_res,
   output logic             rsp_exp_ovf,
   output logic             rsp_res_mismatch,
   output logic             rsp_ovf_mismatch,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
`ifdef CHK_ERR_CAPTURE_EN
   ,
   output logic             err_valid,
   output logic [WIDTH-1:0] err_a,
   output logic [WIDTH-1:0] err_b,
   output logic             err_sub,
   output logic             err_sign
`endif
);

   localparam int unsigned BW = bitcnt_w(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   chk_state_e state, state_nxt;

   logic             accept;
   logic             calc_en;
   logic             cmp_en;
   logic             last_bit;
   logic             rsp_fire;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] cap_res;
   logic             cap_ovf;
   logic             cap_sign;
   logic             cap_sub;
   logic [BW-1:0]    bit_cnt;
   logic             c_msb;
   logic             cout_q;

   logic             fa_s;
   logic             fa_cout;
   logic             fa_c;

   logic             exp_ovf;
   logic             res_mis;
   logic             ovf_mis;

`ifdef CHK_ERR_CAPTURE_EN
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
`endif

   chk_serial_fa u_fa (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .load_c (in_sub),
      .en     (calc_en),
      .a      (a_sh[0]),
      .b      (b_sh[0]),
      .s      (fa_s),
      .cout   (fa_cout),
      .c      (fa_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      calc_en   = 1'b0;
      cmp_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_CALC;
         end
         ST_CALC: begin
            calc_en = 1'b1;
            if (last_bit) state_nxt = ST_CMP;
         end
         ST_CMP: begin
            cmp_en    = 1'b1;
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      accept   = in_valid && in_ready;
      last_bit = (bit_cnt == LAST_BIT);
      rsp_fire = rsp_valid && rsp_ready;
   end

   // Sum bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         sum_sh   <= '0;
         cap_res  <= '0;
         cap_ovf  <= 1'b0;
         cap_sign <= 1'b0;
         cap_sub  <= 1'b0;
         bit_cnt  <= '0;
         c_msb    <= 1'b0;
         cout_q   <= 1'b0;
      end else if (accept) begin
         a_sh     <= in_a;
         b_sh     <= in_sub ? ~in_b : in_b;
         sum_sh   <= '0;
         cap_res  <= in_res;
         cap_ovf  <= in_ovf;
         cap_sign <= in_sign;
         cap_sub  <= in_sub;
         bit_cnt  <= '0;
         c_msb    <= 1'b0;
         cout_q   <= 1'b0;
      end else if (calc_en) begin
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         sum_sh  <= WIDTH'({fa_s, sum_sh} >> 1);
         bit_cnt <= bit_cnt + 1'b1;
         if (last_bit) begin
            c_msb  <= fa_c;
            cout_q <= fa_cout;
         end
      end
   end

   always_comb begin
      if (cap_sign)
         exp_ovf = c_msb ^ cout_q;
      else
         exp_ovf = cap_sub ? ~cout_q : cout_q;
      res_mis = (cap_res != sum_sh);
      ovf_mis = (cap_ovf != exp_ovf);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid        <= 1'b0;
         rsp_pass         <= 1'b0;
         rsp_exp_res      <= '0;
         rsp_exp_ovf      <= 1'b0;
         rsp_res_mismatch <= 1'b0;
         rsp_ovf_mismatch <= 1'b0;
      end else if (cmp_en) begin
         rsp_valid        <= 1'b1;
         rsp_pass         <= !(res_mis || ovf_mis);
         rsp_exp_res      <= sum_sh;
         rsp_exp_ovf      <= exp_ovf;
         rsp_res_mismatch <= res_mis;
         rsp_ovf_mismatch <= ovf_mis;
      end else if (rsp_fire) begin
         rsp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
      end else if (rsp_fire) begin
         if (rsp_pass) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
         end else begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
         end
      end
   end

`ifdef CHK_ERR_CAPTURE_EN
   // Operand shifters are consumed during CALC, so the originals are kept aside.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a      <= '0;
         op_b      <= '0;
         err_valid <= 1'b0;
         err_a     <= '0;
         err_b     <= '0;
         err_sub   <= 1'b0;
         err_sign  <= 1'b0;
      end else begin
         if (accept) begin
            op_a <= in_a;
            op_b <= in_b;
         end
         if (cmp_en && (res_mis || ovf_mis) && !err_valid) begin
            err_valid <= 1'b1;
            err_a     <= op_a;
            err_b     <= op_b;
            err_sub   <= cap_sub;
            err_sign  <= cap_sign;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cla16_result_checker.sv
// Directed-vector bench for cla16_result_checker (default build).
module tb_cla16_result_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic        in_sub = 1'b0;
   logic        in_sign = 1'b0;
   logic [15:0] in_res = '0;
   logic        in_ovf = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_pass;
   logic [15:0] rsp_exp_res;
   logic        rsp_exp_ovf;
   logic        rsp_res_mismatch;
   logic        rsp_ovf_mismatch;
   logic [15:0] pass_cnt;
   logic [15:0] fail_cnt;

   int unsigned n_vec = 0;
   int unsigned n_miss = 0;

   always #5 clk = ~clk;

   cla16_result_checker #(.WIDTH(16), .CNT_W(16)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_a             (in_a),
      .in_b             (in_b),
      .in_sub           (in_sub),
      .in_sign          (in_sign),
      .in_res           (in_res),
      .in_ovf           (in_ovf),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_pass         (rsp_pass),
      .rsp_exp_res      (rsp_exp_res),
      .rsp_exp_ovf      (rsp_exp_ovf),
      .rsp_res_mismatch (rsp_res_mismatch),
      .rsp_ovf_mismatch (rsp_ovf_mismatch),
      .pass_cnt         (pass_cnt),
      .fail_cnt         (fail_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Presents one transaction; returns just after the accept edge.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic sign, input logic [15:0] res, input logic ovf);
      @(negedge clk);
      in_a = a; in_b = b; in_sub = sub; in_sign = sign; in_res = res; in_ovf = ovf;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         if (rsp_valid) break;
         @(posedge clk);
         #1 lat++;
      end
      if (!rsp_valid) lat = -1;
   endtask

   task automatic check_rsp(input string tag, input logic [15:0] er, input logic eo,
                            input logic pass, input logic rm, input logic om);
      chk({tag, ".exp_res"}, 32'(rsp_exp_res), 32'(er));
      chk({tag, ".exp_ovf"}, 32'(rsp_exp_ovf), 32'(eo));
      chk({tag, ".pass"}, 32'(rsp_pass), 32'(pass));
      chk({tag, ".res_mis"}, 32'(rsp_res_mismatch), 32'(rm));
      chk({tag, ".ovf_mis"}, 32'(rsp_ovf_mismatch), 32'(om));
   endtask

   task automatic handshake(input string tag, input int pc, input int fc);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk({tag, ".pass_cnt"}, 32'(pass_cnt), pc);
      chk({tag, ".fail_cnt"}, 32'(fail_cnt), fc);
      chk({tag, ".rsp_valid_drop"}, 32'(rsp_valid), 0);
      chk({tag, ".in_ready_back"}, 32'(in_ready), 1);
   endtask

   typedef struct {
      string       tag;
      logic [15:0] a, b, res;
      logic        sub, sign, ovf;
      logic [15:0] er;
      logic        eo, pass, rm, om;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int lat;
      logic [15:0] h_res;
      int pc, fc;

      vecs[0] = '{"uadd",      16'h0123, 16'h0345, 16'h0468, 0, 0, 0, 16'h0468, 0, 1, 0, 0};
      vecs[1] = '{"uadd_cy",   16'hF123, 16'h1345, 16'h0468, 0, 0, 1, 16'h0468, 1, 1, 0, 0};
      vecs[2] = '{"uadd_ovfm", 16'hF123, 16'h1345, 16'h0468, 0, 0, 0, 16'h0468, 1, 0, 0, 1};
      vecs[3] = '{"usub_resm", 16'hF123, 16'h1345, 16'hDDDF, 1, 0, 0, 16'hDDDE, 0, 0, 1, 0};
      vecs[4] = '{"ssub_ovf",  16'h7123, 16'hA345, 16'hCDDE, 1, 1, 1, 16'hCDDE, 1, 1, 0, 0};
      vecs[5] = '{"sadd",      16'hF123, 16'h1345, 16'h0468, 0, 1, 0, 16'h0468, 0, 1, 0, 0};
      vecs[6] = '{"usub_brw",  16'h0000, 16'h0001, 16'hFFFF, 1, 0, 1, 16'hFFFF, 1, 1, 0, 0};

      #12;
      chk("rst.in_ready", 32'(in_ready), 1);
      chk("rst.rsp_valid", 32'(rsp_valid), 0);
      chk("rst.pass_cnt", 32'(pass_cnt), 0);
      chk("rst.fail_cnt", 32'(fail_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;

      pc = 0; fc = 0;
      foreach (vecs[i]) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sign, vecs[i].res, vecs[i].ovf);
         wait_rsp(lat);
         chk({vecs[i].tag, ".latency"}, 32'(lat), 17);
         check_rsp(vecs[i].tag, vecs[i].er, vecs[i].eo, vecs[i].pass, vecs[i].rm, vecs[i].om);
         if (vecs[i].pass) pc++; else fc++;
         handshake(vecs[i].tag, pc, fc);
      end

      // Backpressure with an ignored mid-CALC request.
      issue(16'h1111, 16'h2222, 0, 0, 16'h3333, 0);
      repeat (5) @(posedge clk);
      #1 chk("bp.in_ready_calc", 32'(in_ready), 0);
      @(negedge clk);
      in_a = 16'hFFFF; in_b = 16'hFFFF; in_res = 16'h0000; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_rsp(lat);
      chk("bp.rsp_seen", 32'(lat >= 0), 1);
      h_res = rsp_exp_res;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("bp.hold_valid", 32'(rsp_valid), 1);
         chk("bp.hold_res", 32'(rsp_exp_res), 32'(h_res));
         chk("bp.in_ready_resp", 32'(in_ready), 0);
         chk("bp.cnt_frozen", 32'(pass_cnt), pc);
      end
      check_rsp("bp", 16'h3333, 0, 1, 0, 0);
      pc++;
      handshake("bp", pc, fc);
      repeat (25) @(posedge clk);
      #1 chk("bp.no_queued_rsp", 32'(rsp_valid), 0);

      // Asynchronous reset in the middle of CALC.
      issue(16'h0001, 16'h0001, 0, 0, 16'h0002, 0);
      repeat (8) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mrst.rsp_valid", 32'(rsp_valid), 0);
      chk("mrst.pass_cnt", 32'(pass_cnt), 0);
      chk("mrst.fail_cnt", 32'(fail_cnt), 0);
      chk("mrst.in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      issue(16'h0123, 16'h0345, 0, 0, 16'h0468, 0);
      wait_rsp(lat);
      chk("post.latency", 32'(lat), 17);
      check_rsp("post", 16'h0468, 0, 1, 0, 0);
      handshake("post", 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
